// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer: multi-cycle control sequencer for the MIPS CPU.
// Each instruction is FETCH followed by 1..N_EXEC execute cycles. The sequencer
// freezes on memory wait-request and parks in HALTED on a datapath halt.
// Optional instruction/stall performance counters: define MIPS_CPU_SEQ_PERF_EN.
module mips_cpu_sequencer #(
  parameter int unsigned N_EXEC = 3,
  parameter int unsigned EXEC_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_waitrequest_i,
  input  logic [EXEC_W:0]   exec_cycles_i,
  input  logic              halt_i,
  output logic              active_o,
  output logic              fetch_o,
  output logic [N_EXEC-1:0] exec_o,
  output logic [EXEC_W-1:0] exec_idx_o,
  output logic              stall_o,
  output logic              instr_done_o
`ifdef MIPS_CPU_SEQ_PERF_EN
  ,
  output logic [31:0]       instr_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  typedef enum logic [1:0] {StReset, StFetch, StExec, StHalted} state_e;

  localparam logic [EXEC_W:0] NExecW = (EXEC_W + 1)'(N_EXEC);

  state_e            state_q, state_d;
  logic [EXEC_W-1:0] idx_q, idx_d;
  logic [EXEC_W:0]   target_q, target_d;

  logic [EXEC_W:0]   n_live;
  logic [EXEC_W:0]   n_cur;
  logic [EXEC_W:0]   idx_next;
  logic              is_last;

  // Resolve the requested execute count into 1..N_EXEC.
  always_comb begin
    if (exec_cycles_i == '0) begin
      n_live = {{EXEC_W{1'b0}}, 1'b1};
    end else if (exec_cycles_i > NExecW) begin
      n_live = NExecW;
    end else begin
      n_live = exec_cycles_i;
    end
  end

  // EXEC0 uses the live count; later cycles use the latched target.
  assign n_cur    = (idx_q == '0) ? n_live : target_q;
  assign idx_next = {1'b0, idx_q} + 1'b1;
  assign is_last  = (state_q == StExec) && (idx_next == n_cur);

  // State, execute index and target registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StReset;
      idx_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; a stalled cycle leaves everything unchanged.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    unique case (state_q)
      StReset: begin
        state_d = StFetch;
        idx_d   = '0;
      end
      StFetch: begin
        if (!mem_waitrequest_i) begin
          state_d = StExec;
          idx_d   = '0;
        end
      end
      StExec: begin
        if (!mem_waitrequest_i) begin
          if (idx_q == '0) begin
            target_d = n_live;
          end
          if (is_last) begin
            idx_d   = '0;
            state_d = halt_i ? StHalted : StFetch;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  // Moore enables plus the combinational stall/done qualifiers.
  always_comb begin
    active_o   = (state_q == StFetch) || (state_q == StExec);
    fetch_o    = (state_q == StFetch);
    exec_o     = '0;
    for (int unsigned k = 0; k < N_EXEC; k++) begin
      exec_o[k] = (state_q == StExec) && (idx_q == EXEC_W'(k));
    end
    exec_idx_o   = (state_q == StExec) ? idx_q : '0;
    stall_o      = active_o && mem_waitrequest_i;
    instr_done_o = is_last && !mem_waitrequest_i;
  end

`ifdef MIPS_CPU_SEQ_PERF_EN
  logic [31:0] instr_count_q, stall_count_q;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (instr_done_o) instr_count_q <= instr_count_q + 32'd1;
      if (stall_o)      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign instr_count_o = instr_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Self-checking bench for mips_cpu_sequencer: directed scenarios plus a
// randomized run, all compared against an instruction-level reference model.
module tb_mips_cpu_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned W = 2;
`ifdef MIPS_CPU_SEQ_PERF_EN
  localparam int VW = 6 + N + W + 64;
`else
  localparam int VW = 6 + N + W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr;
  logic [W:0]   ec;
  logic         h;
  logic         active, fetch, stall, done;
  logic [N-1:0] exec;
  logic [W-1:0] idx;
`ifdef MIPS_CPU_SEQ_PERF_EN
  logic [31:0]  ic, sc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 reset, 1 fetch, 2 execute, 3 halted.
  int          m_mode, m_k, m_n;
  logic [31:0] m_ic, m_sc;

  logic [VW-1:0] obs;

  mips_cpu_sequencer #(.N_EXEC(N), .EXEC_W(W)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mem_waitrequest_i (wr),
    .exec_cycles_i     (ec),
    .halt_i            (h),
    .active_o          (active),
    .fetch_o           (fetch),
    .exec_o            (exec),
    .exec_idx_o        (idx),
    .stall_o           (stall),
    .instr_done_o      (done)
`ifdef MIPS_CPU_SEQ_PERF_EN
    ,
    .instr_count_o     (ic),
    .stall_count_o     (sc)
`endif
  );

  always #5 clk = ~clk;

`ifdef MIPS_CPU_SEQ_PERF_EN
  assign obs = {active, fetch, exec, idx, stall, done, ic, sc};
`else
  assign obs = {active, fetch, exec, idx, stall, done};
`endif

  function automatic int resolve(input logic [W:0] c);
    if (c == 0) return 1;
    if (int'(c) > int'(N)) return int'(N);
    return int'(c);
  endfunction

  function automatic logic [VW-1:0] expected();
    logic a, f, st, d;
    logic [N-1:0] e;
    logic [W-1:0] ix;
    int ne;
    a  = (m_mode == 1) || (m_mode == 2);
    f  = (m_mode == 1);
    e  = '0;
    ix = '0;
    d  = 1'b0;
    if (m_mode == 2) begin
      e[m_k] = 1'b1;
      ix = W'(m_k);
      ne = (m_k == 0) ? resolve(ec) : m_n;
      d  = !wr && (m_k == ne - 1);
    end
    st = a && wr;
`ifdef MIPS_CPU_SEQ_PERF_EN
    return {a, f, e, ix, st, d, m_ic, m_sc};
`else
    return {a, f, e, ix, st, d};
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_n    = 0;
    m_ic   = '0;
    m_sc   = '0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_adv();
    int ne;
    if ((m_mode == 1 || m_mode == 2) && wr) m_sc = m_sc + 1;
    case (m_mode)
      0: m_mode = 1;
      1: if (!wr) begin m_mode = 2; m_k = 0; end
      2: if (!wr) begin
        ne = (m_k == 0) ? resolve(ec) : m_n;
        if (m_k == 0) m_n = ne;
        if (m_k == ne - 1) begin
          m_ic   = m_ic + 1;
          m_mode = h ? 3 : 1;
          m_k    = 0;
        end else begin
          m_k = m_k + 1;
        end
      end
      default: m_mode = 3;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_adv();
    #1;
  endtask

  task automatic reach_fetch(input string name);
    int n = 0;
    while (m_mode != 1 && n < 10) begin
      wr = 1'b0; ec = 3'd1; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL %s_pre: got %h want %h", name, obs, expected());
      end
      tick();
      n++;
    end
    checks++;
    if (m_mode != 1 || fetch !== 1'b1) begin
      errors++;
      $display("FAIL %s_reach_fetch: fetch got %b want 1", name, fetch);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b1; h = 1'b1; ec = 3'd3;
    #1;
    model_reset();
    #3;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    tick();
    rst_n = 1'b1; wr = 1'b0; h = 1'b0; ec = 3'd1;
    #4;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_first_cycle: got %h want 0", obs);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      #4;
      checks++;
      if (obs !== expected() || fetch !== (i % 2 == 0) || done !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL reset_alternate[%0d]: got %h want %h", i, obs, expected());
      end
      tick();
    end
  endtask

  task automatic test_multi();
    logic [N-1:0] ee [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
    logic         ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reach_fetch("multi");
    for (int i = 0; i < 5; i++) begin
      wr = 1'b0; ec = 3'd3; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected() || exec !== ee[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL multi[%0d]: exec got %b want %b done got %b want %b",
                 i, exec, ee[i], done, ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_clamp();
    // ec=0 -> one exec cycle, ec=7 -> three exec cycles.
    logic [W:0]   ce [6] = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [N-1:0] ee [6] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b100};
    logic         ed [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reach_fetch("clamp");
    for (int i = 0; i < 6; i++) begin
      wr = 1'b0; ec = ce[i]; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected() || exec !== ee[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL clamp[%0d]: exec got %b want %b done got %b want %b",
                 i, exec, ee[i], done, ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic         sw [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         ef [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ei [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    logic         ed [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reach_fetch("stall");
    for (int i = 0; i < 8; i++) begin
      wr = sw[i]; ec = 3'd2; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected() || fetch !== ef[i] || idx !== ei[i] ||
          stall !== sw[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL stall[%0d]: got f%b i%0d s%b d%b want f%b i%0d s%b d%b", i,
                 fetch, idx, stall, done, ef[i], ei[i], sw[i], ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic         hw [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         hh [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] ee [5] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b010};
    logic         ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reach_fetch("halt");
    for (int i = 0; i < 5; i++) begin
      wr = hw[i]; ec = 3'd2; h = hh[i];
      #4;
      checks++;
      if (obs !== expected() || exec !== ee[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL halt[%0d]: exec got %b want %b done got %b want %b",
                 i, exec, ee[i], done, ed[i]);
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom); ec = 3'($urandom); h = 1'($urandom);
      #4;
      checks++;
      if (obs !== expected() || active !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL halted[%0d]: got %h want %h", i, obs, expected());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    reach_fetch("reset_mid");
    for (int i = 0; i < 2; i++) begin
      wr = 1'b0; ec = 3'd3; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: got %h want %h", i, obs, expected());
      end
      tick();
    end
    #2;
    checks++;
    if (exec !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_exec1: exec got %b want 010", exec);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h want 0", obs);
    end
    #1;
    tick();
    rst_n = 1'b1;
    #4;
    checks++;
    if (obs !== '0 || obs !== expected()) begin
      errors++;
      $display("FAIL reset_mid_release: got %h want 0", obs);
    end
    tick();
    #4;
    checks++;
    if (fetch !== 1'b1 || obs !== expected()) begin
      errors++;
      $display("FAIL reset_mid_fetch: fetch got %b want 1", fetch);
    end
    tick();
  endtask

`ifdef MIPS_CPU_SEQ_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wr = (i >= 1 && i <= 3); ec = 3'd1; h = 1'b0;
      #4;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL perf[%0d]: got %h want %h", i, obs, expected());
      end
      tick();
    end
    wr = 1'b0;
    #4;
    checks++;
    if (ic !== 32'd5 || sc !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: got instr %0d stall %0d want 5 3", ic, sc);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ic !== 32'd0 || sc !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got instr %0d stall %0d want 0 0", ic, sc);
    end
    tick();
    rst_n = 1'b1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 79) == 0 || (m_mode == 3 && $urandom_range(0, 3) == 0)) begin
        rst_n = 1'b0;
      end
      wr = ($urandom_range(0, 3) == 0);
      ec = 3'($urandom);
      h  = ($urandom_range(0, 9) == 0);
      #1;
      if (!rst_n) model_reset();
      #3;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, expected());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; ec = '0; h = 1'b0;
    model_reset();
    #6;
    test_reset();
    test_multi();
    test_clamp();
    test_stall();
    test_halt();
    test_reset_mid();
`ifdef MIPS_CPU_SEQ_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
